// File: rtl/fpu_float2int.sv
// IEEE 754 binary32 to signed int32 converter, one-bit-per-cycle alignment shifter.
// Optional FPU_F2I_ROUND_EN selects round-to-nearest-even; default build truncates toward zero.
module fpu_float2int (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow,
  output logic        invalid
);

  // state    | meaning
  // IDLE     | waiting for an operand
  // CLASSIFY | decode special cases, load working register and shift count
  // SHIFT    | align mantissa one bit per cycle
  // ROUND    | optional rounding, sign apply, late saturation
  // DONE     | result held until consumer accepts
  typedef enum logic [2:0] {IDLE, CLASSIFY, SHIFT, ROUND, DONE} state_t;

  state_t      state;
  logic [31:0] a_reg;
  logic [31:0] work;
  logic [4:0]  n;
  logic        shift_left;
`ifdef FPU_F2I_ROUND_EN
  logic        guard;
  logic        sticky;
`endif

  logic        sign_f;
  logic [7:0]  exp_f;
  logic [22:0] frac_f;
  logic        round_up;
  logic [31:0] mag;

  assign sign_f   = a_reg[31];
  assign exp_f    = a_reg[30:23];
  assign frac_f   = a_reg[22:0];
  assign in_ready = (state == IDLE) && !rst;

  always_comb begin
    round_up = 1'b0;
`ifdef FPU_F2I_ROUND_EN
    round_up = !shift_left && guard && (sticky || work[0]);
`endif
    // Normal-path magnitudes stay below 2^31, so this add never wraps.
    mag = work + {31'd0, round_up};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_reg      <= 32'd0;
      work       <= 32'd0;
      n          <= 5'd0;
      shift_left <= 1'b0;
      result     <= 32'd0;
      out_valid  <= 1'b0;
      overflow   <= 1'b0;
      invalid    <= 1'b0;
`ifdef FPU_F2I_ROUND_EN
      guard      <= 1'b0;
      sticky     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= a;
            overflow <= 1'b0;
            invalid  <= 1'b0;
            state    <= CLASSIFY;
          end
        end
        CLASSIFY: begin
`ifdef FPU_F2I_ROUND_EN
          guard  <= 1'b0;
          sticky <= 1'b0;
`endif
          work       <= {8'd0, 1'b1, frac_f};
          shift_left <= (exp_f > 8'd150);
          if (exp_f > 8'd150) n <= exp_f[4:0] - 5'd22;
          else                n <= 5'd22 - exp_f[4:0];
          if (exp_f == 8'd0) begin
            result    <= 32'd0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (exp_f == 8'd255) begin
            if (frac_f != 23'd0) begin
              result  <= 32'h8000_0000;
              invalid <= 1'b1;
            end else begin
              result   <= sign_f ? 32'h8000_0000 : 32'h7FFF_FFFF;
              overflow <= 1'b1;
            end
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (exp_f >= 8'd158) begin
            result    <= sign_f ? 32'h8000_0000 : 32'h7FFF_FFFF;
            // Exactly -2^31 is representable.
            overflow  <= !(sign_f && exp_f == 8'd158 && frac_f == 23'd0);
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (exp_f <= 8'd126) begin
            result <= 32'd0;
`ifdef FPU_F2I_ROUND_EN
            if (exp_f == 8'd126 && frac_f != 23'd0)
              result <= sign_f ? 32'hFFFF_FFFF : 32'd1;
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (exp_f == 8'd150) begin
            state <= ROUND;
          end else begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (shift_left) begin
            work <= {work[30:0], 1'b0};
          end else begin
            work <= {1'b0, work[31:1]};
`ifdef FPU_F2I_ROUND_EN
            guard  <= work[0];
            sticky <= sticky | guard;
`endif
          end
          n <= n - 5'd1;
          if (n == 5'd1) state <= ROUND;
        end
        ROUND: begin
          if (!sign_f && mag[31]) begin
            result   <= 32'h7FFF_FFFF;
            overflow <= 1'b1;
          end else begin
            result <= sign_f ? (32'd0 - mag) : mag;
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
